// File: rtl/vdp_pkg.sv
// Shared types and widths for the VDP command unit: command codes,
// VRAM access FSM states and address widths.
package vdp_pkg;

    localparam int VRAM_AW = 14;
    localparam int CRAM_AW = 5;

    typedef enum logic [1:0] {
        CODE_VRD = 2'd0,
        CODE_VWR = 2'd1,
        CODE_REG = 2'd2,
        CODE_CRW = 2'd3
    } vdp_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VWR  = 2'd1,
        ST_VRD  = 2'd2
    } vdp_state_e;

endpackage

// File: rtl/vdp_addr_ctr.sv
// 14-bit VRAM address register with load and increment; a simultaneous load
// and increment advances past the freshly loaded value.
module vdp_addr_ctr
    import vdp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [VRAM_AW-1:0] load_val,
    input  logic               inc,
    input  logic               wrap,
    output logic [VRAM_AW-1:0] addr
);

    logic [VRAM_AW-1:0] base;
    logic [VRAM_AW-1:0] nxt;

    // Without wrap the counter sticks at the top address instead of rolling over.
    always_comb begin
        base = load ? load_val : addr;
        nxt  = base;
        if (inc && (wrap || (base != '1))) begin
            nxt = base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load || inc) begin
            addr <= nxt;
        end
    end

endmodule

// File: rtl/vdp_cmd_unit.sv
// VDP command/data port unit: decodes Z80 port accesses into address loads,
// register/CRAM writes and single-beat VRAM accesses with a read buffer.
module vdp_cmd_unit
    import vdp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               CSW_L,
    input  logic               CSR_L,
    input  logic               MODE,
    input  logic               vdp_go,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic               cram_we,
    output logic [CRAM_AW-1:0] cram_addr,
    output logic [5:0]         cram_wdata,
    output logic               rf_en,
    output logic [3:0]         rf_addr,
    output logic [7:0]         rf_data,
    output logic               cmd_pending,
    output logic               overrun
);

    vdp_state_e         state_q, state_d;
    vdp_code_e          code;
    vdp_code_e          new_code;
    logic               go_q;
    logic [7:0]         tmp;
    logic [7:0]         rbuf;
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_AW-1:0] load_val;
    logic [VRAM_AW-1:0] access_addr;
    logic               evt, ctl_wr, ctl_rd, dat_wr, dat_rd;
    logic               idle, second, dat_drop;
    logic               start_vwr, start_vrd, cram_hit, ack_hit;

    // A write strobe takes precedence if both strobes are low on the same event.
    assign evt    = vdp_go & ~go_q;
    assign ctl_wr = evt & ~CSW_L & MODE;
    assign dat_wr = evt & ~CSW_L & ~MODE;
    assign ctl_rd = evt & CSW_L & ~CSR_L & MODE;
    assign dat_rd = evt & CSW_L & ~CSR_L & ~MODE;

    assign idle        = (state_q == ST_IDLE);
    assign second      = ctl_wr & cmd_pending;
    assign new_code    = vdp_code_e'(data_in[7:6]);
    assign load_val    = {data_in[5:0], tmp};
    assign access_addr = second ? load_val : addr;
    assign dat_drop    = (dat_wr | dat_rd) & ~idle;
    assign start_vwr   = idle & dat_wr & (code != CODE_CRW);
    assign cram_hit    = idle & dat_wr & (code == CODE_CRW);
    assign start_vrd   = idle & (dat_rd | (second & (new_code == CODE_VRD)));
    assign ack_hit     = vram_ack & ~idle;

    assign vram_req = ~idle;
    assign data_out = rbuf;

    vdp_addr_ctr u_addr_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (second),
        .load_val (load_val),
        .inc      (ack_hit | cram_hit),
        .wrap     (1'b1),
        .addr     (addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_vwr) begin
                    state_d = ST_VWR;
                end else if (start_vrd) begin
                    state_d = ST_VRD;
                end
            end
            ST_VWR, ST_VRD: begin
                if (vram_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_q        <= 1'b0;
            code        <= CODE_VRD;
            tmp         <= '0;
            rbuf        <= '0;
            cmd_pending <= 1'b0;
            vram_we     <= 1'b0;
            vram_addr   <= '0;
            vram_wdata  <= '0;
            cram_we     <= 1'b0;
            cram_addr   <= '0;
            cram_wdata  <= '0;
            rf_en       <= 1'b0;
            rf_addr     <= '0;
            rf_data     <= '0;
            overrun     <= 1'b0;
        end else begin
            go_q    <= vdp_go;
            overrun <= dat_drop;
            rf_en   <= second & (new_code == CODE_REG);
            cram_we <= cram_hit;

            if (ctl_wr) begin
                cmd_pending <= ~cmd_pending;
            end else if (ctl_rd || ((dat_wr || dat_rd) && idle)) begin
                cmd_pending <= 1'b0;
            end

            if (ctl_wr && !cmd_pending) begin
                tmp <= data_in;
            end

            if (second) begin
                code <= new_code;
            end

            if (second && (new_code == CODE_REG)) begin
                rf_addr <= data_in[3:0];
                rf_data <= tmp;
            end

            if (cram_hit) begin
                cram_addr  <= addr[CRAM_AW-1:0];
                cram_wdata <= data_in[5:0];
            end

            if (dat_wr && idle) begin
                rbuf <= data_in;
            end else if (ack_hit && (state_q == ST_VRD)) begin
                rbuf <= vram_rdata;
            end

            // Access attributes are captured on FSM entry and held until the ack.
            if (start_vwr) begin
                vram_we    <= 1'b1;
                vram_addr  <= addr;
                vram_wdata <= data_in;
            end else if (start_vrd) begin
                vram_we   <= 1'b0;
                vram_addr <= access_addr;
            end
        end
    end

endmodule

// File: tb/tb_vdp_cmd_unit.sv
// Self-checking bench for vdp_cmd_unit: a VRAM model acks requests and checks
// them against a scoreboard of expected accesses; monitors check rf/cram pulses.
module tb_vdp_cmd_unit;

    logic        clk, rst, CSW_L, CSR_L, MODE, vdp_go;
    logic [7:0]  data_in, data_out;
    logic        vram_req, vram_we, vram_ack;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;
    logic        cram_we, rf_en, cmd_pending, overrun;
    logic [4:0]  cram_addr;
    logic [5:0]  cram_wdata;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_data;
    logic [58:0] outs;

    typedef struct { logic we; logic [13:0] addr; logic [7:0] wdata; } vexp_t;
    typedef struct { logic [3:0] a; logic [7:0] d; } rfexp_t;
    typedef struct { logic [4:0] a; logic [5:0] d; } crexp_t;

    vexp_t  vq[$];
    rfexp_t rq[$];
    crexp_t cq[$];

    logic [7:0] mem [0:16383];
    int checks = 0;
    int errors = 0;
    int rf_cnt = 0;
    int cram_cnt = 0;
    int ovr_cnt = 0;
    logic req_seen = 1'b0;
    logic ack_en = 1'b1;
    logic stray_ack = 1'b0;

    vdp_cmd_unit dut (
        .clk(clk), .rst(rst), .CSW_L(CSW_L), .CSR_L(CSR_L), .MODE(MODE),
        .vdp_go(vdp_go), .data_in(data_in), .data_out(data_out),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
        .rf_en(rf_en), .rf_addr(rf_addr), .rf_data(rf_data),
        .cmd_pending(cmd_pending), .overrun(overrun)
    );

    assign outs = {data_out, vram_req, vram_we, vram_addr, vram_wdata, cram_we,
                   cram_addr, cram_wdata, rf_en, rf_addr, rf_data, cmd_pending, overrun};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: acks two cycles into a request and pops the expected access.
    initial begin
        vexp_t e;
        int wcnt;
        wcnt = 0;
        vram_ack = 1'b0;
        vram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (vram_ack) begin
                vram_ack = 1'b0;
            end else if (rst) begin
                wcnt = 0;
            end else if (stray_ack) begin
                vram_rdata = 8'hEE;
                vram_ack = 1'b1;
            end else if (vram_req && ack_en) begin
                wcnt++;
                if (wcnt >= 2) begin
                    wcnt = 0;
                    checks++;
                    if (vq.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL vram_access unexpected: we=%0b addr=%h", vram_we, vram_addr);
                    end else begin
                        e = vq.pop_front();
                        if (vram_we !== e.we || vram_addr !== e.addr || (e.we && vram_wdata !== e.wdata)) begin
                            errors++;
                            $display("[TB] FAIL vram_access: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                                     vram_we, vram_addr, vram_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                    if (vram_we) mem[vram_addr] = vram_wdata;
                    else vram_rdata = mem[vram_addr];
                    vram_ack = 1'b1;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Pulse monitors for register-file and CRAM writes, overrun and request activity.
    always @(negedge clk) begin
        if (!rst) begin
            if (vram_req) req_seen = 1'b1;
            if (overrun) ovr_cnt++;
            if (rf_en) begin
                rfexp_t r;
                rf_cnt++;
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rf_write unexpected: addr=%h data=%h", rf_addr, rf_data);
                end else begin
                    r = rq.pop_front();
                    if (rf_addr !== r.a || rf_data !== r.d) begin
                        errors++;
                        $display("[TB] FAIL rf_write: got addr=%h data=%h, want addr=%h data=%h", rf_addr, rf_data, r.a, r.d);
                    end
                end
            end
            if (cram_we) begin
                crexp_t c;
                cram_cnt++;
                checks++;
                if (cq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cram_write unexpected: addr=%h data=%h", cram_addr, cram_wdata);
                end else begin
                    c = cq.pop_front();
                    if (cram_addr !== c.a || cram_wdata !== c.d) begin
                        errors++;
                        $display("[TB] FAIL cram_write: got addr=%h data=%h, want addr=%h data=%h", cram_addr, cram_wdata, c.a, c.d);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic mode, input logic wr, input logic [7:0] d);
        @(negedge clk);
        MODE = mode;
        CSW_L = ~wr;
        CSR_L = wr;
        data_in = d;
        vdp_go = 1'b1;
        @(negedge clk);
        vdp_go = 1'b0;
        CSW_L = 1'b1;
        CSR_L = 1'b1;
    endtask

    task automatic push_v(input logic we, input logic [13:0] a, input logic [7:0] d);
        vexp_t e;
        e.we = we; e.addr = a; e.wdata = d;
        vq.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((vram_req || vq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (vram_req || vq.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s timeout: vram_req=%0b pending_expected=%0d, want 0 and 0", tag, vram_req, vq.size());
        end
    endtask

    task automatic test_reset();
        cycles(3);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hold: outputs=%h, want 0", outs);
        end
        rst = 1'b0;
        cycles(2);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release: outputs=%h, want 0", outs);
        end
    endtask

    task automatic test_vram_write_burst();
        bus(1'b1, 1'b1, 8'h00);
        cycles(1);
        checks++;
        if (cmd_pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL burst_pending: got %0b, want 1", cmd_pending);
        end
        bus(1'b1, 1'b1, 8'h40);
        cycles(1);
        checks++;
        if (cmd_pending !== 1'b0 || vram_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst_load: pending=%0b req=%0b, want 0 0", cmd_pending, vram_req);
        end
        push_v(1'b1, 14'h0000, 8'hAA);
        bus(1'b0, 1'b1, 8'hAA);
        wait_idle("burst_w0");
        push_v(1'b1, 14'h0001, 8'h55);
        bus(1'b0, 1'b1, 8'h55);
        wait_idle("burst_w1");
        checks++;
        if (data_out !== 8'h55) begin
            errors++;
            $display("[TB] FAIL burst_rbuf: data_out=%h, want 55", data_out);
        end
        push_v(1'b0, 14'h0002, 8'h00);
        bus(1'b0, 1'b0, 8'h00);
        wait_idle("burst_final_addr");
        checks++;
        if (mem[0] !== 8'hAA || mem[1] !== 8'h55) begin
            errors++;
            $display("[TB] FAIL burst_mem: mem0=%h mem1=%h, want AA 55", mem[0], mem[1]);
        end
    endtask

    task automatic test_register_write();
        rfexp_t r;
        req_seen = 1'b0;
        rf_cnt = 0;
        r.a = 4'h0; r.d = 8'h16;
        bus(1'b1, 1'b1, 8'h16);
        rq.push_back(r);
        bus(1'b1, 1'b1, 8'h80);
        cycles(3);
        checks++;
        if (rf_cnt != 1 || req_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reg_write: rf_cycles=%0d req_seen=%0b, want 1 0", rf_cnt, req_seen);
        end
    endtask

    task automatic test_read_prefetch();
        bus(1'b1, 1'b1, 8'h34);
        push_v(1'b0, 14'h1234, 8'h00);
        bus(1'b1, 1'b1, 8'h12);
        wait_idle("prefetch");
        checks++;
        if (data_out !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL prefetch_data: data_out=%h, want 5A", data_out);
        end
        push_v(1'b0, 14'h1235, 8'h00);
        bus(1'b0, 1'b0, 8'h00);
        checks++;
        if (data_out !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL read_return: data_out=%h, want 5A", data_out);
        end
        wait_idle("read_next");
        checks++;
        if (data_out !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL read_next_data: data_out=%h, want C3", data_out);
        end
        push_v(1'b0, 14'h1236, 8'h00);
        bus(1'b0, 1'b0, 8'h00);
        wait_idle("read_addr_1236");
    endtask

    task automatic test_cram_write();
        crexp_t c;
        req_seen = 1'b0;
        cram_cnt = 0;
        bus(1'b1, 1'b1, 8'h1F);
        bus(1'b1, 1'b1, 8'hC0);
        c.a = 5'h1F; c.d = 6'h3F;
        cq.push_back(c);
        bus(1'b0, 1'b1, 8'hFF);
        cycles(3);
        checks++;
        if (cram_cnt != 1 || req_seen !== 1'b0 || data_out !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL cram_write: cycles=%0d req_seen=%0b data_out=%h, want 1 0 FF", cram_cnt, req_seen, data_out);
        end
    endtask

    task automatic test_latch_clear_wrap();
        bus(1'b1, 1'b1, 8'hFF);
        cycles(1);
        checks++;
        if (cmd_pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latch_set: pending=%0b, want 1", cmd_pending);
        end
        bus(1'b1, 1'b0, 8'h00);
        cycles(1);
        checks++;
        if (cmd_pending !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latch_clear: pending=%0b, want 0", cmd_pending);
        end
        bus(1'b1, 1'b1, 8'hFF);
        bus(1'b1, 1'b1, 8'h7F);
        push_v(1'b1, 14'h3FFF, 8'h9C);
        bus(1'b0, 1'b1, 8'h9C);
        wait_idle("wrap_write");
        push_v(1'b0, 14'h0000, 8'h00);
        bus(1'b0, 1'b0, 8'h00);
        wait_idle("wrap_read");
        checks++;
        if (mem[14'h3FFF] !== 8'h9C || data_out !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL wrap: mem3FFF=%h data_out=%h, want 9C AA", mem[14'h3FFF], data_out);
        end
    endtask

    task automatic test_overrun();
        ack_en = 1'b0;
        ovr_cnt = 0;
        push_v(1'b1, 14'h0001, 8'h11);
        bus(1'b0, 1'b1, 8'h11);
        cycles(2);
        bus(1'b0, 1'b1, 8'h22);
        cycles(2);
        checks++;
        if (ovr_cnt != 1 || vram_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun: pulses=%0d req=%0b, want 1 1", ovr_cnt, vram_req);
        end
        ack_en = 1'b1;
        wait_idle("overrun_recover");
        checks++;
        if (mem[1] !== 8'h11 || mem[2] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL overrun_mem: mem1=%h mem2=%h, want 11 00", mem[1], mem[2]);
        end
    endtask

    task automatic test_reset_mid_access();
        ack_en = 1'b0;
        bus(1'b0, 1'b0, 8'h00);
        checks++;
        if (vram_req !== 1'b1 || vram_we !== 1'b0 || vram_addr !== 14'h0002) begin
            errors++;
            $display("[TB] FAIL midreset_pre: req=%0b we=%0b addr=%h, want 1 0 0002", vram_req, vram_we, vram_addr);
        end
        cycles(1);
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_async: outputs=%h, want 0", outs);
        end
        cycles(2);
        rst = 1'b0;
        ack_en = 1'b1;
        stray_ack = 1'b1;
        cycles(4);
        stray_ack = 1'b0;
        cycles(2);
        checks++;
        if (vram_req !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL stray_ack: req=%0b data_out=%h, want 0 00", vram_req, data_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h1234] = 8'h5A;
        mem[14'h1235] = 8'hC3;
        rst = 1'b1;
        CSW_L = 1'b1;
        CSR_L = 1'b1;
        MODE = 1'b0;
        vdp_go = 1'b0;
        data_in = 8'h00;
        test_reset();
        test_vram_write_burst();
        test_register_write();
        test_read_prefetch();
        test_cram_write();
        test_latch_clear_wrap();
        test_overrun();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
